// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures high time and period from edge pulses, presented on a valid/ready result register
module pulse_period_meter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             rise_p,
    input  logic             fall_p,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             sat,
    output logic             overrun,
    input  logic             clr_overrun
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    localparam logic [CNT_W-1:0] MAX = '1;
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_inc, hi_lat;
    logic hi_sat, rise, fall, done, load, set_ovr;
    // Coincident rise and fall pulses cancel each other out
    assign rise    = rise_p & ~fall_p;
    assign fall    = fall_p & ~rise_p;
    assign cnt_inc = (cnt == MAX) ? cnt : cnt + 1'b1;
    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // Next state: any clean rise (re)starts HIGH, a fall in HIGH moves to LOW
    always_comb begin
        state_nxt = !en ? IDLE : rise ? HIGH : (state == HIGH && fall) ? LOW : state;
    end
    // Outputs of the FSM: measurement completion and result-register acceptance
    always_comb begin
        done    = en & rise & (state == LOW);
        load    = done & (~meas_valid | meas_ready);
        set_ovr = done & meas_valid & ~meas_ready;
    end
    // Saturating cycle counter and high-time latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            hi_lat <= '0;
            hi_sat <= 1'b0;
        end else begin
            cnt <= !en ? '0 : rise ? CNT_W'(1) : (state == IDLE) ? '0 : cnt_inc;
            if (en && state == HIGH && fall) begin
                hi_lat <= cnt;
                hi_sat <= (cnt == MAX);
            end
        end
    end
    // Result register with handshake and sticky overrun (set beats clear)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meas_valid <= 1'b0;
            high_time  <= '0;
            period     <= '0;
            sat        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                meas_valid <= 1'b1;
                high_time  <= hi_lat;
                period     <= cnt;
                sat        <= hi_sat | (cnt == MAX);
            end else if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
            end
            overrun <= set_ovr | (overrun & ~clr_overrun);
        end
    end
endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter: randomized and directed scoreboard bench for two widths of pulse_period_meter
module tb_pulse_period_meter;
    logic clk = 0, rst_n = 0, en = 1, rise_p = 0, fall_p = 0, meas_ready = 1, clr_overrun = 0;
    logic mv16, sat16, ov16, mv4, sat4, ov4;
    logic [15:0] ht16, per16;
    logic [3:0] ht4, per4;
    int checks = 0, errors = 0;

    typedef struct {int ht; int per; bit s;} res_t;
    res_t q [2][$];
    int mx [2] = '{65535, 15};
    bit armed [2], fell [2], mv [2], ovr [2];
    int t0 [2], t1 [2];
    int cyc = 0;

    always #5 clk = ~clk;

    pulse_period_meter #(.CNT_W(16)) u16 (
        .clk(clk), .rst_n(rst_n), .en(en), .rise_p(rise_p), .fall_p(fall_p),
        .meas_valid(mv16), .meas_ready(meas_ready), .high_time(ht16), .period(per16),
        .sat(sat16), .overrun(ov16), .clr_overrun(clr_overrun)
    );
    pulse_period_meter #(.CNT_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en), .rise_p(rise_p), .fall_p(fall_p),
        .meas_valid(mv4), .meas_ready(meas_ready), .high_time(ht4), .period(per4),
        .sat(sat4), .overrun(ov4), .clr_overrun(clr_overrun)
    );

    // Reference model: measurements from pulse timestamps, capped at each width's maximum
    always @(posedge clk) begin : model
        res_t r;
        bit done, set, rr, ff;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                armed[i] = 0; fell[i] = 0; mv[i] = 0; ovr[i] = 0;
                q[i].delete();
            end else begin
                done = 0;
                rr = rise_p && !fall_p;
                ff = fall_p && !rise_p;
                if (!en) begin
                    armed[i] = 0; fell[i] = 0;
                end else if (rr) begin
                    if (armed[i] && fell[i]) begin
                        done = 1;
                        r.ht  = (t1[i] - t0[i] > mx[i]) ? mx[i] : t1[i] - t0[i];
                        r.per = (cyc - t0[i] > mx[i]) ? mx[i] : cyc - t0[i];
                        r.s   = (t1[i] - t0[i] >= mx[i]) || (cyc - t0[i] >= mx[i]);
                    end
                    armed[i] = 1; fell[i] = 0; t0[i] = cyc;
                end else if (ff && armed[i] && !fell[i]) begin
                    fell[i] = 1; t1[i] = cyc;
                end
                set = done && mv[i] && !meas_ready;
                if (done && !set) begin
                    q[i].push_back(r);
                    mv[i] = 1;
                end else if (mv[i] && meas_ready) begin
                    mv[i] = 0;
                end
                if (set) ovr[i] = 1;
                else if (clr_overrun) ovr[i] = 0;
            end
        end
        cyc++;
    end

    task automatic chk(input int i, input logic v, input int ht, input int per, input logic s, input logic ov);
        checks++;
        if (v !== mv[i]) begin
            errors++;
            $display("FAIL inst%0d valid: got %b want %b at cyc %0d", i, v, mv[i], cyc);
        end
        checks++;
        if (ov !== ovr[i]) begin
            errors++;
            $display("FAIL inst%0d overrun: got %b want %b at cyc %0d", i, ov, ovr[i], cyc);
        end
        if (v === 1'b1) begin
            checks++;
            if (q[i].size() == 0) begin
                errors++;
                $display("FAIL inst%0d result: got valid with no expected result at cyc %0d", i, cyc);
            end else begin
                if (ht != q[i][0].ht || per != q[i][0].per || s !== q[i][0].s) begin
                    errors++;
                    $display("FAIL inst%0d result: got ht=%0d per=%0d sat=%b want ht=%0d per=%0d sat=%b at cyc %0d",
                             i, ht, per, s, q[i][0].ht, q[i][0].per, q[i][0].s, cyc);
                end
                if (meas_ready) void'(q[i].pop_front());
            end
        end
    endtask

    // Monitor: compares presented results against the scoreboard, pops on transfer
    always @(negedge clk) begin
        chk(0, mv16, int'(ht16), int'(per16), sat16, ov16);
        chk(1, mv4, int'(ht4), int'(per4), sat4, ov4);
    end

    task automatic expect_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic step(input bit r, input bit f);
        rise_p = r; fall_p = f;
        @(posedge clk); #1;
        rise_p = 0; fall_p = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0);
    endtask

    task automatic rearm();
        en = 0; step(0, 0); en = 1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        expect_eq("reset valid", int'(mv16), 0);
        expect_eq("reset high_time", int'(ht16), 0);
        expect_eq("reset period", int'(per16), 0);
        expect_eq("reset sat", int'(sat16), 0);
        expect_eq("reset overrun", int'(ov16), 0);
        rst_n = 1;
        idle(4);
        step(1, 0); idle(2); step(0, 1); idle(4); step(1, 0);
        expect_eq("basic valid", int'(mv16), 1);
        expect_eq("basic high_time", int'(ht16), 3);
        expect_eq("basic period", int'(per16), 8);
        expect_eq("basic sat", int'(sat16), 0);
        idle(1);
        expect_eq("basic valid one cycle", int'(mv16), 0);
        rearm();
        for (int k = 0; k < 5; k++) begin
            step(1, 0); idle(3); step(0, 1); idle(5);
        end
        step(1, 0);
        expect_eq("square high_time", int'(ht16), 4);
        expect_eq("square period", int'(per16), 10);
        meas_ready = 0;
        idle(3); step(0, 1); idle(5); step(1, 0);
        idle(3); step(0, 1); idle(5); step(1, 0);
        expect_eq("held valid", int'(mv16), 1);
        expect_eq("held period", int'(per16), 10);
        expect_eq("overrun set", int'(ov16), 1);
        en = 0; meas_ready = 1; step(0, 0);
        meas_ready = 0;
        expect_eq("drained valid", int'(mv16), 0);
        clr_overrun = 1; step(0, 0); clr_overrun = 0;
        expect_eq("overrun cleared", int'(ov16), 0);
        en = 1; meas_ready = 1;
        step(1, 0); idle(19); step(0, 1); idle(4); step(1, 0);
        expect_eq("sat4 high_time", int'(ht4), 15);
        expect_eq("sat4 period", int'(per4), 15);
        expect_eq("sat4 sat", int'(sat4), 1);
        expect_eq("sat16 high_time", int'(ht16), 20);
        expect_eq("sat16 period", int'(per16), 25);
        expect_eq("sat16 sat", int'(sat16), 0);
        rearm();
        step(1, 0); idle(5); step(1, 0); idle(1); step(0, 1); idle(2); step(1, 0);
        expect_eq("restart high_time", int'(ht16), 2);
        expect_eq("restart period", int'(per16), 5);
        rearm();
        step(1, 0); idle(2); en = 0; step(0, 1); step(1, 0); idle(2); en = 1;
        idle(1); step(0, 1); idle(1);
        expect_eq("abort no result", int'(mv16), 0);
        step(1, 0); idle(3); step(0, 1); idle(4); step(1, 0);
        expect_eq("post-enable high_time", int'(ht16), 4);
        expect_eq("post-enable period", int'(per16), 9);
        meas_ready = 0;
        rearm();
        step(1, 0); idle(2); step(0, 1); idle(2); step(1, 0);
        expect_eq("pending valid", int'(mv16), 1);
        rst_n = 0; step(0, 0); rst_n = 1;
        expect_eq("reset drops valid", int'(mv16), 0);
        for (int k = 0; k < 3000; k++) begin
            en = ($urandom % 50) != 0;
            meas_ready = ($urandom % 4) != 0;
            clr_overrun = ($urandom % 20) == 0;
            step(($urandom % 12) == 0, ($urandom % 9) == 0);
        end
        en = 0; meas_ready = 1; clr_overrun = 0;
        idle(5);
        expect_eq("drain queue16", q[0].size(), 0);
        expect_eq("drain queue4", q[1].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Consumes the single-cycle rising-edge and falling-edge pulses produced by the edge-detector stage.
- Measures high time and full period of the underlying signal in clk cycles.
- Presents each completed measurement on a valid/ready output register.
- Downstream consumers are status registers or a measurement FIFO.

Parameters:
CNT_W, 16, width of the cycle counter and of both result fields; counts saturate at 2^CNT_W-1

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
en  input  1  measurement enable; 0 aborts the measurement in flight and holds the FSM in IDLE
rise_p  input  1  one-cycle pulse marking a rising edge of the measured signal
fall_p  input  1  one-cycle pulse marking a falling edge of the measured signal
meas_valid  output  1  result register holds an unconsumed measurement
meas_ready  input  1  consumer accepts the result when meas_valid & meas_ready
high_time  output  CNT_W  cycles from rise pulse to fall pulse
period  output  CNT_W  cycles from rise pulse to next rise pulse
sat  output  1  either field of the current result saturated
overrun  output  1  sticky; a completed measurement was dropped because the result register was occupied
clr_overrun  input  1  one-cycle clear of overrun

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM=IDLE, cnt=0, hi_lat=0, hi_sat=0. All outputs 0: meas_valid, high_time, period, sat, overrun.
- FSM states: IDLE, HIGH, LOW.
- rise_p and fall_p both 1 in the same cycle: both ignored; FSM and cnt follow the no-pulse rules.
- IDLE:
  - rise_p=1 & en=1 -> HIGH, cnt<=1.
  - fall_p is ignored.
- HIGH:
  - cnt<=sat(cnt+1) each cycle.
  - fall_p=1 -> LOW, hi_lat<=cnt, hi_sat<=(cnt==MAX), cnt<=sat(cnt+1).
  - rise_p=1 (missed fall) -> restart: stay HIGH, cnt<=1, no result produced.
- LOW:
  - cnt<=sat(cnt+1) each cycle.
  - fall_p is ignored.
  - rise_p=1 -> measurement complete: new result = {high_time=hi_lat, period=cnt, sat=hi_sat|(cnt==MAX)}. FSM -> HIGH, cnt<=1, so back-to-back periods are measured without gaps.
- Counter convention: cnt register is loaded with 1 at the rise-pulse edge. With rise pulse at cycle t0 and fall pulse at cycle t1, high_time = t1-t0. Period = t2-t0, where t2 is the next rise-pulse cycle.
- Saturation: cnt holds at 2^CNT_W-1 and never wraps.
- Output latency: a result completed at cycle t2 appears on the outputs with meas_valid=1 at cycle t2+1 (registered).
- Handshake:
  - high_time, period and sat are stable while meas_valid=1 and meas_ready=0.
  - Transfer occurs on a clk edge with meas_valid & meas_ready; meas_valid then clears unless a new result loads in the same cycle.
  - New result while meas_valid=1 & meas_ready=0: the new result is dropped and overrun<=1.
  - New result in the same cycle as a transfer: the new result loads and meas_valid stays 1; no overrun.
- overrun: set as above; cleared by clr_overrun. If set and clear occur in the same cycle, set wins.
- en=0: FSM<=IDLE and cnt<=0 next edge. A pending result register and overrun are kept, and the handshake keeps operating. The partial measurement is discarded.
- Reset mid-operation: all state and a pending result are lost; behaviour is identical to power-up reset.

Test Plan:
- Reset, en=1, rise_p at cycle 10, fall_p at 13, rise_p at 18, meas_ready=1 -> meas_valid=1 at cycle 19 only, high_time=3, period=8, sat=0.
- Continuous square wave, rise every 10 cycles, fall 4 after each rise, meas_ready=1 -> one result per period, every result high_time=4, period=10. The first result arrives 1 cycle after the second rise.
- meas_ready=0 across two completed periods -> the first result is held stable, the second is dropped, overrun=1. Then meas_ready=1 for one cycle -> the first result transfers and meas_valid=0. clr_overrun -> overrun=0.
- CNT_W=4, rise_p, fall_p 20 cycles later, rise_p 5 cycles after that -> high_time=15, period=15, sat=1.
- Rise, then a second rise after 6 cycles with no fall, then fall after 2, then rise after 3 more -> the first rise is discarded; single result high_time=2, period=5.
- en dropped mid-HIGH, pulses continue, en raised, then a full rise/fall/rise sequence -> no result from the aborted measurement; the next result measures only the post-enable pulses correctly. rst_n=0 asserted while meas_valid=1 -> meas_valid=0 next edge.
